sig_halt_periph: RTL and testbench

//   Memory-mapped test-host responder on the peripheral data bus (dbus2peri side).
//   - Accepts core stores of signature words and a halt command.
//   - Buffers signature words in a FIFO and drains them on a ready/valid stream to an off-chip/host sink.
//   - Raises a sticky halt once the halt command is seen and the FIFO has drained.
//   - Replaces bench-side address snooping for compliance runs; sits beside the UART/GPIO peripherals.

---
 rtl/sig_halt_pkg.sv | 26 ++
 rtl/sig_fifo.sv | 55 +++++
 rtl/sig_halt_periph.sv | 161 ++++++++++++++++
 tb/tb_sig_halt_periph.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sig_halt_pkg.sv
// Shared constants for the signature/halt test-host responder: bus map, FSM states, status layout.
// Pure declarations, no logic.
package sig_halt_pkg;

  localparam logic [31:0] SIG_ADDR_DEF  = 32'h001F_FE68;
  localparam logic [31:0] HALT_ADDR_DEF = 32'h001F_FE6C;
  localparam logic [31:0] STAT_ADDR_DEF = 32'h001F_FE70;
  localparam logic [31:0] CYC_ADDR_OFS  = 32'd4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int STAT_EMPTY_BIT  = 0;
  localparam int STAT_FULL_BIT   = 1;
  localparam int STAT_HALTED_BIT = 2;
  localparam int STAT_ERR_BIT    = 3;
  localparam int STAT_CNT_LSB    = 8;

  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/sig_fifo.sv
// Synchronous FIFO; data visible at head the cycle after a push, pop acts on the same edge.
// Push at full is only taken when a pop happens in the same cycle; pop on empty is ignored.
module sig_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] head_dat,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  cnt
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign cnt      = cnt_q;
  assign head_dat = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/sig_halt_periph.sv
// Test-host responder: signature stores stream out via a FIFO, halt store raises sticky halt_o once drained.
// Ack one cycle after acceptance; SIG stores stall while the FIFO is full. Optional SIG_HALT_CYCLE_CNT_EN adds a cycle counter.
module sig_halt_periph
  import sig_halt_pkg::*;
#(
  parameter logic [31:0] SIG_ADDR   = SIG_ADDR_DEF,
  parameter logic [31:0] HALT_ADDR  = HALT_ADDR_DEF,
  parameter logic [31:0] STAT_ADDR  = STAT_ADDR_DEF,
  parameter int          FIFO_DEPTH = 8,
  parameter int          DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              sig_valid_o,
  output logic [DATA_W-1:0] sig_data_o,
  input  logic              sig_ready_i,
  output logic              halt_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state_q;
  state_t            state_d;
  logic              ack_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [DATA_W-1:0] fifo_head;
  logic              pop;
  logic              push;

  logic              hit_sig;
  logic              hit_halt;
  logic              hit_stat;
  logic              sig_st;
  logic              halt_st;
  logic              stall;
  logic              accept;
  logic [DATA_W-1:0] stat_word;
  logic [DATA_W-1:0] rd_d;

  assign hit_sig  = (addr_i == SIG_ADDR);
  assign hit_halt = (addr_i == HALT_ADDR);
  assign hit_stat = (addr_i == STAT_ADDR);
  assign sig_st   = req_i && we_i && hit_sig;
  assign halt_st  = req_i && we_i && hit_halt;

  assign pop    = !fifo_empty && sig_ready_i;
  // Only a live SIG push can stall; once halting, SIG stores are dropped instead.
  assign stall  = sig_st && (state_q == RUN) && fifo_full && !pop;
  assign accept = req_i && !ack_q && !stall;
  assign push   = accept && sig_st && (state_q == RUN);

  sig_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (wdata_i),
    .pop      (pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .cnt      (fifo_cnt)
  );

  assign sig_valid_o = !fifo_empty;
  assign sig_data_o  = fifo_empty ? '0 : fifo_head;
  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;

  always_comb begin
    stat_word = '0;
    stat_word[STAT_EMPTY_BIT]          = fifo_empty;
    stat_word[STAT_FULL_BIT]           = fifo_full;
    stat_word[STAT_HALTED_BIT]         = (state_q == HALTED);
    stat_word[STAT_ERR_BIT]            = err_q;
    stat_word[STAT_CNT_LSB +: 8]       = sat8(32'(fifo_cnt));
  end

`ifdef SIG_HALT_CYCLE_CNT_EN
  logic [31:0] cyc_q;
  logic        hit_cyc;

  assign hit_cyc = (addr_i == STAT_ADDR + CYC_ADDR_OFS);

  // Free-running from reset; stops once HALTED so the run length stays readable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else if (state_q != HALTED) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end
`endif

  always_comb begin
    rd_d = '0;
    if (!we_i) begin
      if (hit_stat) begin
        rd_d = stat_word;
      end
`ifdef SIG_HALT_CYCLE_CNT_EN
      else if (hit_cyc) begin
        rd_d = DATA_W'(cyc_q);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ack_q   <= accept;
      rdata_q <= accept ? rd_d : '0;
      if (accept && sig_st && (state_q != RUN)) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    halt_o  = 1'b0;
    case (state_q)
      RUN: begin
        if (accept && halt_st) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) state_d = HALTED;
      end
      HALTED: begin
        halt_o = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_sig_halt_periph.sv
// Directed bench for sig_halt_periph: stream words scored against a queue of expected signature data.
module tb_sig_halt_periph;
  import sig_halt_pkg::*;

  localparam logic [31:0] SIG  = SIG_ADDR_DEF;
  localparam logic [31:0] HLT  = HALT_ADDR_DEF;
  localparam logic [31:0] STAT = STAT_ADDR_DEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        sig_valid_o;
  logic [31:0] sig_data_o;
  logic        sig_ready_i = 1'b0;
  logic        halt_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];

  sig_halt_periph dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .ack_o       (ack_o),
    .rdata_o     (rdata_o),
    .sig_valid_o (sig_valid_o),
    .sig_data_o  (sig_data_o),
    .sig_ready_i (sig_ready_i),
    .halt_o      (halt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Stream monitor: every handshake must match the oldest outstanding signature word.
  always @(negedge clk) begin
    if (rst_n && sig_valid_o && sig_ready_i) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL stream_extra observed=%h expected=no_word", sig_data_o);
      end
      if (exp_q.size() != 0) chk("stream_data", sig_data_o, exp_q.pop_front());
    end
  end

  task automatic bus_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
    logic done;
    @(posedge clk); #1;
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
    lat = 0;
    done = 1'b0;
    do begin
      @(posedge clk); #1;
      done = ack_o;
      if (!done) lat++;
    end while (!done && lat < 50);
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL bus_timeout observed=no_ack expected=ack addr=%h", addr);
    end
    rd = rdata_o;
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input string tag);
    logic [31:0] rd;
    int lat;
    bus_op(1'b1, addr, wd, rd, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd0);
  endtask

  task automatic sig_wr(input logic [31:0] wd, input string tag);
    exp_q.push_back(wd);
    wr(SIG, wd, tag);
  endtask

  task automatic rd_chk(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    int lat;
    bus_op(1'b0, addr, 32'd0, rd, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd0);
    chk(tag, rd, exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    req_i = 1'b0; sig_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [31:0] c0, c1;
    int lat;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_valid", 32'(sig_valid_o), 32'd0);
    chk("rst_data", sig_data_o, 32'd0);
    chk("rst_halt", 32'(halt_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd_chk(STAT, 32'h0000_0001, "stat_reset");

    // In-order streaming with a ready sink
    sig_ready_i = 1'b1;
    sig_wr(32'hA5A5_0001, "t1_w1");
    sig_wr(32'hA5A5_0002, "t1_w2");
    sig_wr(32'hA5A5_0003, "t1_w3");
    @(posedge clk); #1;
    chk("ack_width", 32'(ack_o), 32'd0);
    repeat (4) @(posedge clk); #1;
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // Fill to full, stall the ninth store, release via a pop
    sig_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) sig_wr(32'hB000_0000 + 32'(i), "t2_fill");
    rd_chk(STAT, 32'h0000_0802, "stat_full");
    exp_q.push_back(32'hB000_0008);
    @(posedge clk); #1;
    req_i = 1'b1; we_i = 1'b1; addr_i = SIG; wdata_i = 32'hB000_0008;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("stall_noack", 32'(ack_o), 32'd0);
    end
    sig_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("stall_ack_on_pop", 32'(ack_o), 32'd1);
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    repeat (12) @(posedge clk); #1;
    chk("t2_drained", 32'(exp_q.size()), 32'd0);
    chk("t2_valid_low", 32'(sig_valid_o), 32'd0);

    // Halt with three words queued: halt_o one cycle after the last pop
    sig_ready_i = 1'b0;
    sig_wr(32'hC000_0001, "t3_w1");
    sig_wr(32'hC000_0002, "t3_w2");
    sig_wr(32'hC000_0003, "t3_w3");
    wr(HLT, 32'h0, "t3_halt");
    chk("t3_halt_pending", 32'(halt_o), 32'd0);
    rd_chk(STAT, 32'h0000_0300, "stat_drain");
    sig_ready_i = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("t3_last_popped", 32'(exp_q.size()), 32'd0);
    chk("t3_halt_not_early", 32'(halt_o), 32'd0);
    @(posedge clk); #1;
    chk("t3_halt_rise", 32'(halt_o), 32'd1);

    // Stores after halt are dropped and flag err; other accesses are inert
    wr(SIG, 32'hDEAD_0000, "t4_sig_dropped");
    repeat (3) @(posedge clk); #1;
    chk("t4_valid_idle", 32'(sig_valid_o), 32'd0);
    rd_chk(STAT, 32'h0000_000D, "stat_err_halt");
    rd_chk(SIG, 32'h0, "ld_sig_addr");
    wr(STAT, 32'hFFFF_FFFF, "st_stat_addr");
    rd_chk(32'h0000_1000, 32'h0, "ld_other_addr");
    rd_chk(STAT, 32'h0000_000D, "stat_unchanged");

    // Halt from an empty FIFO, then a repeated halt
    do_reset();
    wr(HLT, 32'h0, "t3b_halt");
    chk("t3b_halt_ack_cycle", 32'(halt_o), 32'd0);
    @(posedge clk); #1;
    chk("t3b_halt_next", 32'(halt_o), 32'd1);
    wr(HLT, 32'h0, "t3b_halt_again");
    chk("t3b_halt_held", 32'(halt_o), 32'd1);
    rd_chk(STAT, 32'h0000_0005, "stat_halted");

    // Async reset clears halt immediately
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 chk("rst_halt_async", 32'(halt_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Async reset mid-drain
    sig_ready_i = 1'b0;
    sig_wr(32'hE000_0001, "t5_w1");
    sig_wr(32'hE000_0002, "t5_w2");
    wr(HLT, 32'h0, "t5_halt");
    chk("t5_valid_before", 32'(sig_valid_o), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_valid_async", 32'(sig_valid_o), 32'd0);
    chk("t5_halt_async", 32'(halt_o), 32'd0);
    chk("t5_ack_async", 32'(ack_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd_chk(STAT, 32'h0000_0001, "stat_after_rst");

    // Cycle counter
    bus_op(1'b0, STAT + 32'd4, 32'd0, c0, lat);
    repeat (8) @(posedge clk);
    bus_op(1'b0, STAT + 32'd4, 32'd0, c1, lat);
`ifdef SIG_HALT_CYCLE_CNT_EN
    chk("cyc_delta", c1 - c0, 32'd10);
    wr(HLT, 32'h0, "t6_halt");
    repeat (3) @(posedge clk);
    bus_op(1'b0, STAT + 32'd4, 32'd0, c0, lat);
    repeat (8) @(posedge clk);
    bus_op(1'b0, STAT + 32'd4, 32'd0, c1, lat);
    chk("cyc_frozen", c1 - c0, 32'd0);
`else
    chk("cyc_absent_0", c0, 32'd0);
    chk("cyc_absent_1", c1, 32'd0);
`endif

    chk("sb_final_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
